// File: rtl/operand_shifter.sv
// Iterative one-bit-per-clock LSL/LSR/ASR/ROR shifter feeding the ALU B operand.
// Define SHIFTER_RRX_EN to make ROR #0 perform a single-step RRX.
module operand_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       shType,
    input  logic [AMT_W-1:0] shAmt,
    input  logic [WIDTH-1:0] inVal,
    input  logic             carryIn,
    output logic [WIDTH-1:0] shOut,
    output logic             shC,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         typ_q, typ_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               c_q, c_d;
    logic               rrx_q, rrx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            typ_q   <= SH_LSL;
            out_q   <= '0;
            c_q     <= 1'b0;
            rrx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            typ_q   <= typ_d;
            out_q   <= out_d;
            c_q     <= c_d;
            rrx_q   <= rrx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        typ_d   = typ_q;
        out_d   = out_q;
        c_d     = c_q;
        rrx_d   = rrx_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    out_d   = inVal;
                    c_d     = carryIn;
                    typ_d   = shType;
                    cnt_d   = shAmt;
                    rrx_d   = 1'b0;
                    state_d = (shAmt == '0) ? DONE : SHIFT;
`ifdef SHIFTER_RRX_EN
                    // RRX: one rotate step with the old C flag as fill bit
                    if (shType == SH_ROR && shAmt == '0) begin
                        rrx_d   = 1'b1;
                        cnt_d   = AMT_W'(1);
                        state_d = SHIFT;
                    end
`endif
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
                unique case (typ_q)
                    SH_LSL: begin
                        c_d   = out_q[WIDTH-1];
                        out_d = {out_q[WIDTH-2:0], 1'b0};
                    end
                    SH_LSR: begin
                        c_d   = out_q[0];
                        out_d = {1'b0, out_q[WIDTH-1:1]};
                    end
                    SH_ASR: begin
                        c_d   = out_q[0];
                        out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                    end
                    SH_ROR: begin
                        c_d   = out_q[0];
                        out_d = {rrx_q ? c_q : out_q[0], out_q[WIDTH-1:1]};
                    end
                    default: begin
                        c_d   = c_q;
                        out_d = out_q;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign shOut = out_q;
    assign shC   = c_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_operand_shifter.sv
// Directed bench for operand_shifter: vector table plus multi-cycle corner sequences.
// Build with SHIFTER_RRX_EN to check the RRX variant of ROR #0.
module tb_operand_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  shType;
    logic [4:0]  shAmt;
    logic [31:0] inVal;
    logic        carryIn;
    logic [31:0] shOut;
    logic        shC;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    operand_shifter #(.WIDTH(32), .AMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .shType  (shType),
        .shAmt   (shAmt),
        .inVal   (inVal),
        .carryIn (carryIn),
        .shOut   (shOut),
        .shC     (shC),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  amt;
        logic [31:0] val;
        logic        cin;
        int          lat;
        logic [31:0] eo;
        logic        ec;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; request is sampled on the following posedge.
    task automatic issue(input logic [1:0] t, input logic [4:0] a,
                         input logic [31:0] v, input logic c);
        start   = 1'b1;
        shType  = t;
        shAmt   = a;
        inVal   = v;
        carryIn = c;
    endtask

    // Entered at the negedge of cycle 1; returns at the negedge of the done cycle.
    task automatic wait_done(output int cyc, output logic bsy_ok);
        cyc    = 1;
        bsy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (busy !== 1'b1) bsy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        logic bo;
        logic [31:0] held;
        issue(v.typ, v.amt, v.val, v.cin);
        @(negedge clk);
        start = 1'b0;
        inVal = ~v.val;
        carryIn = ~v.cin;
        wait_done(cyc, bo);
        chk($sformatf("v%0d latency", idx), cyc, v.lat);
        chk($sformatf("v%0d shOut", idx), shOut, v.eo);
        chk($sformatf("v%0d shC", idx), {31'b0, shC}, {31'b0, v.ec});
        chk($sformatf("v%0d busy_during", idx), {31'b0, bo}, 32'd1);
        chk($sformatf("v%0d busy_at_done", idx), {31'b0, busy}, 32'd0);
        held = shOut;
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), {31'b0, done}, 32'd0);
        chk($sformatf("v%0d hold", idx), shOut, held);
    endtask

    initial begin
        int   cyc;
        logic bo;
        logic seen;

        vecs[0]  = '{2'b00, 5'd1,  32'h80000001, 1'b0, 2,  32'h00000002, 1'b1};
        vecs[1]  = '{2'b10, 5'd4,  32'h80000000, 1'b0, 5,  32'hF8000000, 1'b0};
        vecs[2]  = '{2'b11, 5'd4,  32'h000000F1, 1'b0, 5,  32'h1000000F, 1'b0};
        vecs[3]  = '{2'b01, 5'd31, 32'hFFFFFFFF, 1'b0, 32, 32'h00000001, 1'b1};
        vecs[4]  = '{2'b00, 5'd0,  32'h12345678, 1'b1, 1,  32'h12345678, 1'b1};
        vecs[5]  = '{2'b01, 5'd31, 32'h80000000, 1'b1, 32, 32'h00000001, 1'b0};
        vecs[6]  = '{2'b00, 5'd31, 32'h00000001, 1'b1, 32, 32'h80000000, 1'b0};
        vecs[7]  = '{2'b10, 5'd1,  32'h7FFFFFFF, 1'b0, 2,  32'h3FFFFFFF, 1'b1};
        vecs[8]  = '{2'b11, 5'd1,  32'h00000001, 1'b0, 2,  32'h80000000, 1'b1};
        vecs[9]  = '{2'b00, 5'd2,  32'hC0000000, 1'b0, 3,  32'h00000000, 1'b1};
        vecs[10] = '{2'b10, 5'd31, 32'h80000001, 1'b1, 32, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{2'b01, 5'd0,  32'hA5A5A5A5, 1'b0, 1,  32'hA5A5A5A5, 1'b0};
`ifdef SHIFTER_RRX_EN
        vecs[12] = '{2'b11, 5'd0,  32'h12345678, 1'b1, 2,  32'h891A2B3C, 1'b0};
`else
        vecs[12] = '{2'b11, 5'd0,  32'h12345678, 1'b1, 1,  32'h12345678, 1'b1};
`endif

        rst = 1'b1;
        start = 1'b0;
        shType = 2'b00;
        shAmt = 5'd0;
        inVal = 32'h0;
        carryIn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset shOut", shOut, 32'h0);
        chk("reset shC", {31'b0, shC}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back: start held during the DONE cycle of a ROR #4
        issue(2'b11, 5'd4, 32'h000000F1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bo);
        chk("b2b first latency", cyc, 5);
        chk("b2b first shOut", shOut, 32'h1000000F);
        chk("b2b first shC", {31'b0, shC}, 32'd0);
        issue(2'b01, 5'd31, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second busy", {31'b0, busy}, 32'd1);
        wait_done(cyc, bo);
        chk("b2b second latency", cyc, 32);
        chk("b2b second shOut", shOut, 32'h00000001);
        chk("b2b second shC", {31'b0, shC}, 32'd1);
        @(negedge clk);

        // start during SHIFT is ignored and not queued
        issue(2'b00, 5'd8, 32'h00000001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(2'b01, 5'd3, 32'h0000FFFF, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bo);
        cyc = cyc + 2;
        chk("ignore latency", cyc, 9);
        chk("ignore shOut", shOut, 32'h00000100);
        chk("ignore shC", {31'b0, shC}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("ignore no queued op", {31'b0, seen}, 32'd0);

        // Reset during SHIFT aborts with no done pulse
        issue(2'b01, 5'd10, 32'hF0F0F0F0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort shOut", shOut, 32'h0);
        chk("abort shC", {31'b0, shC}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort no done", {31'b0, seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
